// File: rtl/buzzer_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_arbiter_pkg
// Shared types and helpers for the buzzer arbiter slice.
//   arb_state_t : arbiter FSM states (idle / beep on / silent gap)
//   max_cyc()   : larger of two cycle counts, used to size the phase counter
// -----------------------------------------------------------------------------
package buzzer_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_PLAY = 2'd1,
      ARB_GAP  = 2'd2
   } arb_state_t;

   function automatic int max_cyc(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/buzzer_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority selector. The search starts at ptr+1 and
// wraps modulo N_REQ, so the index granted last has the lowest priority.
//   elig  : eligible mask, one bit per requester
//   ptr   : index of the most recent winner
//   win   : one-hot winner (all zero when nothing is eligible)
//   idx   : binary index of the winner
//   valid : at least one requester is eligible
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] elig,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] win,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   localparam logic [N_REQ-1:0] ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

   // Scan ptr+1, ptr+2, ... and keep the first eligible candidate.
   always_comb begin : scan
      int         cand_s;
      logic [IDX_W-1:0] cand_idx_s;
      logic       hit_s;
      idx   = '0;
      valid = 1'b0;
      cand_s     = 0;
      cand_idx_s = '0;
      hit_s      = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand_s     = (int'(ptr) + i) % N_REQ;
         cand_idx_s = IDX_W'(cand_s);
         hit_s      = elig[cand_idx_s] & ~valid;
         idx        = hit_s ? cand_idx_s : idx;
         valid      = valid | hit_s;
      end
      win = valid ? (ONE_HOT_LSB << idx) : '0;
   end

endmodule

// File: rtl/buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// buzzer_arbiter
// Shares one board buzzer among N_REQ alarm sources. A round-robin pick grants
// one eligible source (request high and non-zero tone) at a time; the winner
// gets one beep of BEEP_ON_CYC cycles followed by a BEEP_OFF_CYC silent gap,
// then one idle arbitration cycle. All outputs are registered.
//   clk_i     : system clock
//   rst_i     : synchronous reset, active-high
//   req_i     : level request per source
//   cmp_i     : packed tone compare per source, source i at [i*CMP_W +: CMP_W]
//   gnt_o     : one-hot grant, held through beep and gap
//   done_o    : one-cycle pulse when the granted beep completes (not on abort)
//   buz_en_o  : buzzer enable, high only while the beep plays
//   buz_cmp_o : tone compare latched at grant time
//   busy_o    : high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module buzzer_arbiter
   import buzzer_arbiter_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CMP_W        = 22,
   parameter int BEEP_ON_CYC  = 5_000_000,
   parameter int BEEP_OFF_CYC = 2_500_000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*CMP_W-1:0] cmp_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic [N_REQ-1:0]       done_o,
   output logic                   buz_en_o,
   output logic [CMP_W-1:0]       buz_cmp_o,
   output logic                   busy_o
);

   localparam int IDX_W   = $clog2(N_REQ);
   localparam int MAX_CYC = max_cyc(BEEP_ON_CYC, BEEP_OFF_CYC);
   localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

   // Counters load N-1 so that N cycles elapse before the zero test fires.
   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(BEEP_ON_CYC - 1);
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(BEEP_OFF_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

   logic [CMP_W-1:0] cmp_arr_s [N_REQ];
   logic [N_REQ-1:0] elig_s;
   logic [N_REQ-1:0] pick_win_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic             pick_valid_s;

   arb_state_t       state_r;
   logic [IDX_W-1:0] ptr_r;
   logic [CNT_W-1:0] cnt_r;
   logic [N_REQ-1:0] gnt_r;
   logic [N_REQ-1:0] done_r;
   logic             en_r;
   logic [CMP_W-1:0] cmp_r;
   logic             busy_r;

   // A zero tone would be silent, so such a source is never eligible.
   for (genvar g = 0; g < N_REQ; g++) begin : g_src
      assign cmp_arr_s[g] = cmp_i[g*CMP_W +: CMP_W];
      assign elig_s[g]    = req_i[g] & (|cmp_arr_s[g]);
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .elig  (elig_s),
      .ptr   (ptr_r),
      .win   (pick_win_s),
      .idx   (pick_idx_s),
      .valid (pick_valid_s)
   );

   // Arbiter FSM with phase counter and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ARB_IDLE;
         ptr_r   <= PTR_RST;
         cnt_r   <= '0;
         gnt_r   <= '0;
         done_r  <= '0;
         en_r    <= 1'b0;
         cmp_r   <= '0;
         busy_r  <= 1'b0;
      end else begin
         done_r <= '0;
         case (state_r)
            ARB_IDLE: begin
               if (pick_valid_s) begin
                  gnt_r   <= pick_win_s;
                  cmp_r   <= cmp_arr_s[pick_idx_s];
                  ptr_r   <= pick_idx_s;
                  cnt_r   <= ON_LOAD;
                  en_r    <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= ARB_PLAY;
               end else begin
                  state_r <= ARB_IDLE;
               end
            end
            ARB_PLAY: begin
               // A withdrawn request silences the beep at once and skips done.
               if (!req_i[ptr_r]) begin
                  en_r    <= 1'b0;
                  cnt_r   <= OFF_LOAD;
                  state_r <= ARB_GAP;
               end else if (cnt_r == '0) begin
                  done_r  <= gnt_r;
                  en_r    <= 1'b0;
                  cnt_r   <= OFF_LOAD;
                  state_r <= ARB_GAP;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ARB_GAP: begin
               if (cnt_r == '0) begin
                  gnt_r   <= '0;
                  busy_r  <= 1'b0;
                  state_r <= ARB_IDLE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_r <= ARB_IDLE;
               cnt_r   <= '0;
               gnt_r   <= '0;
               en_r    <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o     = gnt_r;
   assign done_o    = done_r;
   assign buz_en_o  = en_r;
   assign buz_cmp_o = cmp_r;
   assign busy_o    = busy_r;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buzzer_arbiter
// Self-checking bench for buzzer_arbiter with short beep timing (ON=4, OFF=2).
// A timestamp-based reference model (grant edge, end-of-beep edge) predicts
// every output; directed scenarios also check fixed expected values.
// -----------------------------------------------------------------------------
module tb_buzzer_arbiter;

   localparam int N   = 4;
   localparam int CW  = 22;
   localparam int ON  = 4;
   localparam int OFF = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [CW-1:0]   cmpv [N];
   logic [N*CW-1:0] cmp_bus;
   logic [N-1:0]    gnt_o;
   logic [N-1:0]    done_o;
   logic            buz_en_o;
   logic [CW-1:0]   buz_cmp_o;
   logic            busy_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model: owner index, grant edge, edge where the beep ended
   int            m_owner;
   int            m_ptr;
   int            m_g;
   int            m_end;
   logic [CW-1:0] m_cmp;
   logic [N-1:0]  m_done;
   logic [N-1:0]  e_gnt;
   logic          e_en;
   logic          e_busy;

   always #5 clk = ~clk;

   assign cmp_bus = {cmpv[3], cmpv[2], cmpv[1], cmpv[0]};

   buzzer_arbiter #(
      .N_REQ        (N),
      .CMP_W        (CW),
      .BEEP_ON_CYC  (ON),
      .BEEP_OFF_CYC (OFF)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .cmp_i     (cmp_bus),
      .gnt_o     (gnt_o),
      .done_o    (done_o),
      .buz_en_o  (buz_en_o),
      .buz_cmp_o (buz_cmp_o),
      .busy_o    (busy_o)
   );

   // Advance one clock edge and update the model from the inputs seen there.
   task automatic step();
      int k;
      @(posedge clk);
      #1;
      cyc++;
      m_done = '0;
      if (rst) begin
         m_owner = -1;
         m_ptr   = N - 1;
         m_end   = -1;
         m_cmp   = '0;
      end else if (m_owner >= 0) begin
         if (m_end < 0) begin
            if (!req[m_owner]) begin
               m_end = cyc;
            end else if (cyc == m_g + ON) begin
               m_end  = cyc;
               m_done = 4'b0001 << m_owner;
            end
         end else if (cyc == m_end + OFF) begin
            m_owner = -1;
         end
      end else begin
         for (int i = 1; i <= N; i++) begin
            k = (m_ptr + i) % N;
            if (m_owner < 0 && req[k] && cmpv[k] != 22'd0) begin
               m_owner = k;
               m_cmp   = cmpv[k];
               m_ptr   = k;
               m_g     = cyc;
               m_end   = -1;
            end
         end
      end
      e_gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e_en   = (m_owner >= 0) && (m_end < 0);
      e_busy = (m_owner >= 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      for (int i = 0; i < N; i++) cmpv[i] = 22'd0;
      step();
      step();
      total++;
      if ({gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o} !== 33'd0) begin
         bad++;
         $display("FAIL reset_state got=%h want=0", {gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o});
      end
      rst     = 1'b0;
      req     = 4'b0100;
      cmpv[2] = 22'd1000;
      step();
      step();
      total++;
      if (buz_en_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre_play got en=%b want 1", buz_en_o);
      end
      rst = 1'b1;
      step();
      total++;
      if ({buz_en_o, gnt_o, busy_o} !== 6'b0) begin
         bad++;
         $display("FAIL reset_mid_play got en=%b gnt=%b busy=%b want all 0", buz_en_o, gnt_o, busy_o);
      end
      rst     = 1'b0;
      req     = 4'b0001;
      cmpv[0] = 22'd5000;
      step();
      total++;
      if (gnt_o !== 4'b0001 || buz_cmp_o !== 22'd5000) begin
         bad++;
         $display("FAIL reset_then_grant0 got gnt=%b cmp=%0d want 0001 5000", gnt_o, buz_cmp_o);
      end
   endtask

   task automatic test_single_beep();
      logic [N-1:0] x_gnt;
      logic [N-1:0] x_done;
      logic         x_en;
      do_reset();
      req     = 4'b0100;
      cmpv[2] = 22'd125000;
      for (int j = 1; j <= 10; j++) begin
         step();
         total++;
         if ({gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o} !== {e_gnt, m_done, e_en, e_busy, m_cmp}) begin
            bad++;
            $display("FAIL beep_model cyc=%0d got=%h want=%h", cyc,
                     {gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o}, {e_gnt, m_done, e_en, e_busy, m_cmp});
         end
         x_en   = (j <= 4);
         x_done = (j == 5) ? 4'b0100 : 4'b0000;
         x_gnt  = (j <= 6) ? 4'b0100 : 4'b0000;
         total++;
         if ({gnt_o, done_o, buz_en_o} !== {x_gnt, x_done, x_en} || (x_en && buz_cmp_o !== 22'd125000)) begin
            bad++;
            $display("FAIL beep_timing j=%0d got gnt=%b done=%b en=%b cmp=%0d want gnt=%b done=%b en=%b cmp=125000",
                     j, gnt_o, done_o, buz_en_o, buz_cmp_o, x_gnt, x_done, x_en);
         end
         if (j == 5) req = 4'b0000;
      end
   endtask

   task automatic test_round_robin();
      int           order [6];
      int           n_g;
      int           low_run;
      logic         seen;
      logic [N-1:0] prev;
      order = '{0, 1, 3, 0, 1, 3};
      n_g = 0;
      low_run = 0;
      seen = 1'b0;
      do_reset();
      prev = '0;
      req = 4'b1011;
      cmpv[0] = 22'd100;
      cmpv[1] = 22'd200;
      cmpv[3] = 22'd300;
      for (int j = 1; j <= 44; j++) begin
         step();
         total++;
         if ({gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o} !== {e_gnt, m_done, e_en, e_busy, m_cmp}) begin
            bad++;
            $display("FAIL rr_model cyc=%0d got=%h want=%h", cyc,
                     {gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o}, {e_gnt, m_done, e_en, e_busy, m_cmp});
         end
         if (prev == 4'b0000 && gnt_o != 4'b0000 && n_g < 6) begin
            total++;
            if (gnt_o !== (4'b0001 << order[n_g])) begin
               bad++;
               $display("FAIL rr_order turn=%0d got gnt=%b want source %0d", n_g, gnt_o, order[n_g]);
            end
            n_g++;
         end
         if (buz_en_o === 1'b1) begin
            if (seen && low_run > 0) begin
               total++;
               if (low_run != 3) begin
                  bad++;
                  $display("FAIL rr_silence got %0d silent cycles want 3", low_run);
               end
            end
            low_run = 0;
            seen = 1'b1;
         end else if (seen) begin
            low_run++;
         end
         prev = gnt_o;
      end
      total++;
      if (n_g != 6) begin
         bad++;
         $display("FAIL rr_count got %0d grants want 6", n_g);
      end
   endtask

   task automatic test_abort();
      do_reset();
      req     = 4'b0010;
      cmpv[1] = 22'd3333;
      for (int j = 1; j <= 7; j++) begin
         step();
         total++;
         if ({gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o} !== {e_gnt, m_done, e_en, e_busy, m_cmp}) begin
            bad++;
            $display("FAIL abort_model cyc=%0d got=%h want=%h", cyc,
                     {gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o}, {e_gnt, m_done, e_en, e_busy, m_cmp});
         end
         total++;
         if (buz_en_o !== (j <= 2) || done_o !== 4'b0000 || gnt_o !== ((j <= 4) ? 4'b0010 : 4'b0000)) begin
            bad++;
            $display("FAIL abort_timing j=%0d got en=%b done=%b gnt=%b", j, buz_en_o, done_o, gnt_o);
         end
         if (j == 2) req = 4'b0000;
      end
   endtask

   task automatic test_zero_tone();
      do_reset();
      req     = 4'b0011;
      cmpv[0] = 22'd0;
      cmpv[1] = 22'd62500;
      for (int j = 1; j <= 20; j++) begin
         step();
         total++;
         if ({gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o} !== {e_gnt, m_done, e_en, e_busy, m_cmp}) begin
            bad++;
            $display("FAIL zero_model cyc=%0d got=%h want=%h", cyc,
                     {gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o}, {e_gnt, m_done, e_en, e_busy, m_cmp});
         end
         total++;
         if (gnt_o[0] !== 1'b0 || (j <= 4 && (buz_cmp_o !== 22'd62500 || gnt_o !== 4'b0010))) begin
            bad++;
            $display("FAIL zero_tone j=%0d got gnt=%b cmp=%0d want gnt=0010 cmp=62500 early, never source 0",
                     j, gnt_o, buz_cmp_o);
         end
         if (j == 2) cmpv[1] = 22'd777;
      end
   endtask

   task automatic test_late_request();
      do_reset();
      req     = 4'b0001;
      cmpv[0] = 22'd1111;
      cmpv[3] = 22'd2222;
      for (int j = 1; j <= 9; j++) begin
         step();
         total++;
         if ({gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o} !== {e_gnt, m_done, e_en, e_busy, m_cmp}) begin
            bad++;
            $display("FAIL late_model cyc=%0d got=%h want=%h", cyc,
                     {gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o}, {e_gnt, m_done, e_en, e_busy, m_cmp});
         end
         if (j == 8) begin
            total++;
            if (gnt_o !== 4'b1000 || buz_cmp_o !== 22'd2222) begin
               bad++;
               $display("FAIL late_request got gnt=%b cmp=%0d want 1000 2222", gnt_o, buz_cmp_o);
            end
         end
         if (j == 5) req = 4'b1001;
      end
   endtask

   task automatic test_random();
      int s;
      do_reset();
      for (int j = 0; j < 800; j++) begin
         if ($urandom_range(0, 7) == 0) begin
            s = $urandom_range(0, N - 1);
            req[s] = ~req[s];
         end
         if ($urandom_range(0, 15) == 0) begin
            s = $urandom_range(0, N - 1);
            cmpv[s] = ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom_range(1, 4000000));
         end
         rst = ($urandom_range(0, 299) == 0);
         step();
         total++;
         if ({gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o} !== {e_gnt, m_done, e_en, e_busy, m_cmp}) begin
            bad++;
            $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc,
                     {gnt_o, done_o, buz_en_o, busy_o, buz_cmp_o}, {e_gnt, m_done, e_en, e_busy, m_cmp});
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_g     = 0;
      m_end   = -1;
      m_cmp   = '0;
      m_done  = '0;
      rst     = 1'b1;
      req     = '0;
      for (int i = 0; i < N; i++) cmpv[i] = 22'd0;
      test_reset();
      test_single_beep();
      test_round_robin();
      test_abort();
      test_zero_tone();
      test_late_request();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
